imem_fetch_ctrl: RTL and testbench

//  Instruction-fetch sequencer in front of the synchronous IMEM (1-cycle registered read, output zeroed on RST).

---
 rtl/imem_fetch_ctrl.sv | 99 +++++++++
 tb/tb_imem_fetch_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues IMEM reads, and buffers responses in a 2-entry FIFO.
// Optional build macro FETCH_ALIGN_CHECK_EN turns misaligned redirects into a sticky fetch fault.
module imem_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        fetch_fault
);

    logic [31:0] pc_q;
    logic [31:0] req_pc_q;
    logic        inflight_q;
    logic [1:0]  count_q;
    logic [31:0] fifo_pc_q    [2];
    logic [31:0] fifo_instr_q [2];
    logic        fault_q;

    logic [31:0] redir_tgt;
    logic        redir_bad;
    logic        redir_ok;
    logic        pop;
    logic        push;
    logic        issue;
    logic        credit_ok;
    logic [2:0]  occupancy;
    logic [1:0]  count_after_pop;

`ifdef FETCH_ALIGN_CHECK_EN
    assign redir_tgt = redirect_pc;
    assign redir_bad = redirect_valid & (redirect_pc[1:0] != 2'b00);
`else
    logic unused_low_bits;
    assign unused_low_bits = ^redirect_pc[1:0];
    assign redir_tgt       = {redirect_pc[31:2], 2'b00};
    assign redir_bad       = 1'b0;
`endif

    assign redir_ok  = redirect_valid & ~redir_bad;
    assign imem_addr = redirect_valid ? redir_tgt : pc_q;

    assign out_valid   = (count_q != 2'd0);
    assign out_pc      = fifo_pc_q[0];
    assign out_instr   = fifo_instr_q[0];
    assign fetch_fault = fault_q;

    assign pop = out_valid & out_ready;

    // Credits cover both buffered entries and the response still on its way from IMEM.
    assign occupancy       = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign credit_ok       = (occupancy < 3'd2);
    assign issue           = redirect_valid ? redir_ok : (credit_ok & ~fault_q);
    assign push            = inflight_q & ~redirect_valid;
    assign count_after_pop = count_q - {1'b0, pop};

    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_q       <= RESET_PC;
            req_pc_q   <= RESET_PC;
            inflight_q <= 1'b0;
            count_q    <= '0;
            fault_q    <= 1'b0;
            for (int unsigned i = 0; i < 2; i++) begin
                fifo_pc_q[i]    <= '0;
                fifo_instr_q[i] <= '0;
            end
        end else begin
            inflight_q <= issue;
            if (issue) begin
                req_pc_q <= imem_addr;
                pc_q     <= imem_addr + 32'd4;
            end
            if (redirect_valid) begin
                count_q <= '0;
                fault_q <= redir_bad;
            end else begin
                if (pop) begin
                    fifo_pc_q[0]    <= fifo_pc_q[1];
                    fifo_instr_q[0] <= fifo_instr_q[1];
                end
                // Written after the shift so a push into the freed head slot takes precedence.
                if (push) begin
                    fifo_pc_q[count_after_pop[0]]    <= req_pc_q;
                    fifo_instr_q[count_after_pop[0]] <= imem_instr;
                end
                count_q <= count_after_pop + {1'b0, push};
            end
        end
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: stream scoreboard, redirect vector table, corner sequences.
`timescale 1ns/1ps
module tb_imem_fetch_ctrl;

`ifdef FETCH_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif
    localparam int STREAM_LEN = 128;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] imem_addr, imem_instr;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc, out_instr;
    logic        fetch_fault;

    logic [31:0] imem_addr2, imem_instr2, out_pc2, out_instr2;
    logic        out_valid2, fetch_fault2;

    int n_cmp = 0;
    int n_err = 0;
    int xfers = 0;
    int xfers2 = 0;

    always #5 CLK = ~CLK;

    imem_fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .CLK(CLK), .RST(RST),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_addr(imem_addr), .imem_instr(imem_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr),
        .fetch_fault(fetch_fault)
    );

    imem_fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .CLK(CLK), .RST(RST),
        .redirect_valid(1'b0), .redirect_pc(32'h0000_0000),
        .imem_addr(imem_addr2), .imem_instr(imem_instr2),
        .out_valid(out_valid2), .out_ready(1'b1),
        .out_pc(out_pc2), .out_instr(out_instr2),
        .fetch_fault(fetch_fault2)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = a >> 2;
        return (w * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // IMEM models: one-cycle registered read, output cleared in reset
    always @(posedge CLK) begin
        imem_instr  <= RST ? 32'h0 : mem_word(imem_addr);
        imem_instr2 <= RST ? 32'h0 : mem_word(imem_addr2);
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    logic [31:0] exp_q[$];

    task automatic push_stream(input logic [31:0] start);
        for (int i = 0; i < STREAM_LEN; i++)
            exp_q.push_back(start + 32'(4 * i));
    endtask

    // Scoreboard: expected PC stream, restarted on reset and on each redirect
    logic        hold_pending = 1'b0;
    logic [31:0] hold_pc, hold_instr;
    always @(negedge CLK) begin
        logic [31:0] e;
        if (RST) begin
            exp_q.delete();
            push_stream(32'h0);
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                check1("hold_valid", out_valid, 1'b1);
                check32("hold_pc", out_pc, hold_pc);
                check32("hold_instr", out_instr, hold_instr);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL stream_extra: got pc %h expected no transfer", out_pc);
                end else begin
                    e = exp_q.pop_front();
                    check32("stream_pc", out_pc, e);
                    check32("stream_instr", out_instr, mem_word(e));
                    xfers++;
                end
            end
            hold_pending = out_valid && !out_ready && !redirect_valid;
            hold_pc      = out_pc;
            hold_instr   = out_instr;
            if (redirect_valid) begin
                exp_q.delete();
                if (!(ALIGN_CHK && redirect_pc[1:0] != 2'b00))
                    push_stream({redirect_pc[31:2], 2'b00});
            end
        end
    end

    logic [31:0] exp2;
    always @(negedge CLK) begin
        if (RST) begin
            exp2   = 32'hFFFF_FFF8;
            xfers2 = 0;
        end else if (out_valid2) begin
            check32("wrap_pc", out_pc2, exp2);
            check32("wrap_instr", out_instr2, mem_word(exp2));
            exp2 = exp2 + 32'd4;
            xfers2++;
        end
    end

    typedef struct {
        int unsigned pre;
        logic        ready_pre;
        logic [31:0] target;
        logic        exp_fault;
        logic [31:0] exp_pc;
    } vec_t;

    localparam int NV = 5;
    vec_t vecs[NV];

    initial begin
        int snap;
        vecs[0] = '{3, 1'b1, 32'h0000_0100, 1'b0, 32'h0000_0100};
        vecs[1] = '{4, 1'b0, 32'h0000_0200, 1'b0, 32'h0000_0200};
`ifdef FETCH_ALIGN_CHECK_EN
        vecs[2] = '{2, 1'b1, 32'h0000_0102, 1'b1, 32'h0000_0000};
`else
        vecs[2] = '{2, 1'b1, 32'h0000_0102, 1'b0, 32'h0000_0100};
`endif
        vecs[3] = '{3, 1'b1, 32'h0000_0104, 1'b0, 32'h0000_0104};
        vecs[4] = '{1, 1'b0, 32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFFC};

        // Reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            tick();
            check1("rst_valid", out_valid, 1'b0);
            check1("rst_fault", fetch_fault, 1'b0);
            check32("rst_addr", imem_addr, 32'h0);
            check32("rst_addr_wrap", imem_addr2, 32'hFFFF_FFF8);
        end
        RST = 1'b0;
        out_ready = 1'b1;

        @(negedge CLK);
        check1("lat_c0_valid", out_valid, 1'b0);
        check32("lat_c0_addr", imem_addr, 32'h0);
        @(negedge CLK);
        check1("lat_c1_valid", out_valid, 1'b0);
        check32("lat_c1_addr", imem_addr, 32'h4);
        @(negedge CLK);
        check1("lat_c2_valid", out_valid, 1'b1);
        check32("lat_c2_pc", out_pc, 32'h0);

        tick();
        snap = xfers;
        repeat (10) tick();
        check32("throughput", 32'(xfers - snap), 32'd10);

        out_ready = 1'b0;
        repeat (5) tick();
        out_ready = 1'b1;
        repeat (8) tick();

        repeat (12) begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
        end

        for (int v = 0; v < NV; v++) begin
            out_ready = vecs[v].ready_pre;
            repeat (vecs[v].pre) tick();
            redirect_valid = 1'b1;
            redirect_pc    = vecs[v].target;
            out_ready      = 1'b1;
            tick();
            redirect_valid = 1'b0;
            @(negedge CLK);
            check1("redir_flush", out_valid, 1'b0);
            if (vecs[v].exp_fault) begin
                repeat (4) @(negedge CLK);
                check1("fault_valid", out_valid, 1'b0);
                check1("fault_set", fetch_fault, 1'b1);
            end else begin
                @(negedge CLK);
                check1("redir_valid", out_valid, 1'b1);
                check32("redir_pc", out_pc, vecs[v].exp_pc);
                check32("redir_instr", out_instr, mem_word(vecs[v].exp_pc));
                check1("redir_fault", fetch_fault, 1'b0);
            end
            tick();
            repeat (6) begin
                out_ready = 1'($urandom_range(0, 1));
                tick();
            end
            out_ready = 1'b1;
        end

        // Back-to-back redirects: only the second target is delivered
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0040;
        tick();
        redirect_pc    = 32'h0000_0080;
        tick();
        redirect_valid = 1'b0;
        @(negedge CLK);
        check1("b2b_flush", out_valid, 1'b0);
        @(negedge CLK);
        check1("b2b_valid", out_valid, 1'b1);
        check32("b2b_pc", out_pc, 32'h0000_0080);
        tick();
        repeat (6) tick();

        // Reset in the middle of a stalled stream
        out_ready = 1'b0;
        repeat (3) tick();
        RST = 1'b1;
        tick();
        check1("midrst_valid", out_valid, 1'b0);
        check32("midrst_addr", imem_addr, 32'h0);
        RST = 1'b0;
        out_ready = 1'b1;
        @(negedge CLK);
        check1("midrst_c0_valid", out_valid, 1'b0);
        @(negedge CLK);
        check1("midrst_c1_valid", out_valid, 1'b0);
        @(negedge CLK);
        check1("midrst_c2_valid", out_valid, 1'b1);
        check32("midrst_pc", out_pc, 32'h0);
        tick();
        repeat (10) tick();

        check1("wrap_seen", (xfers2 >= 3), 1'b1);
        check1("stream_seen", (xfers >= 40), 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
